// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W = 20
);
    // start is taken only while busy=0; busy rises on the accepting edge.
    // done pulses for one cycle on the edge that updates bcd_out and ovf.
    logic [BIN_W-1:0] bin_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [23:0]      bcd_out;
    logic             ovf;

    modport master (
        output bin_in, start,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  bin_in, start,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 converter, one input bit per clock, into a held 6-digit BCD register.
// Optional overflow saturation to FFFFFF is built only when BIN_TO_BCD_OVF_EN is defined.
module bin_to_bcd_seq #(
    parameter int BIN_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus,
    output logic             dbg_state
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [BIN_W-1:0] shreg;
    logic [23:0]      scratch;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [23:0]      bcd_r;
    logic [23:0]      adj;
    logic [23:0]      scratch_nxt;

`ifdef BIN_TO_BCD_OVF_EN
    logic             ovf_flag;
    logic             ovf_r;
`endif

    // Correct every digit before the shift so each doubles into a valid BCD digit.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 6; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = scratch[4*i +: 4];
        end
        scratch_nxt = {adj[22:0], shreg[BIN_W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
`ifdef BIN_TO_BCD_OVF_EN
            ovf_flag <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
`ifdef BIN_TO_BCD_OVF_EN
                        ovf_flag <= (32'(bus.bin_in) > 32'd999999);
`endif
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
`ifdef BIN_TO_BCD_OVF_EN
                        bcd_r <= ovf_flag ? 24'hFFFFFF : scratch_nxt;
                        ovf_r <= ovf_flag;
`else
                        bcd_r <= scratch_nxt;
`endif
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bcd_out = bcd_r;
`ifdef BIN_TO_BCD_OVF_EN
    assign bus.ovf     = ovf_r;
`else
    assign bus.ovf     = 1'b0;
`endif
    assign dbg_state   = state;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized checks of bin_to_bcd_seq against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;
    localparam int BIN_W = 20;

    logic clk;
    logic rst;
    logic dbg_state;
    int   checks;
    int   errors;
    logic [23:0] cur_bcd;
    logic        cur_ovf;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_ovf(input int unsigned v);
`ifdef BIN_TO_BCD_OVF_EN
        return v > 999999;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0]  r;
        int unsigned  x;
        if (ref_ovf(v)) return 24'hFFFFFF;
        r = '0;
        x = v % 1000000;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one conversion starting in the current cycle; optionally pokes start mid-flight.
    task automatic convert(input int unsigned v, input bit noisy);
        logic [23:0] exp_bcd;
        logic        exp_ovf;
        exp_bcd = ref_bcd(v);
        exp_ovf = ref_ovf(v);
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(v);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.bin_in = BIN_W'($urandom);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_after_start", 32'(bus.done), 32'd0);
        chk("state_after_start", 32'(dbg_state), 32'd1);
        chk("bcd_hold_start", 32'(bus.bcd_out), 32'(cur_bcd));
        for (int k = 1; k < BIN_W; k++) begin
            if (noisy && (k == 3 || k == 10)) begin
                bus.start  = 1'b1;
                bus.bin_in = BIN_W'(777);
            end else begin
                bus.start  = 1'b0;
                bus.bin_in = BIN_W'($urandom);
            end
            @(posedge clk); #1;
            chk("busy_during", 32'(bus.busy), 32'd1);
            chk("done_during", 32'(bus.done), 32'd0);
            chk("bcd_hold", 32'(bus.bcd_out), 32'(cur_bcd));
            chk("ovf_hold", 32'(bus.ovf), 32'(cur_ovf));
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("state_end", 32'(dbg_state), 32'd0);
        chk("bcd_result", 32'(bus.bcd_out), 32'(exp_bcd));
        chk("ovf_result", 32'(bus.ovf), 32'(exp_ovf));
        cur_bcd = exp_bcd;
        cur_ovf = exp_ovf;
    endtask

    task automatic idle_cycle();
        bus.start  = 1'b0;
        bus.bin_in = BIN_W'($urandom);
        @(posedge clk); #1;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_bcd", 32'(bus.bcd_out), 32'(cur_bcd));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cur_bcd    = '0;
        cur_ovf    = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        convert(0, 1'b0);
        idle_cycle();
        convert(123456, 1'b0);
        idle_cycle();
        convert(999999, 1'b0);
        convert(65535, 1'b0);
        idle_cycle();
        convert(1048575, 1'b0);
        idle_cycle();
        convert(42, 1'b1);
        idle_cycle();
        idle_cycle();

        // Reset ten cycles into a conversion of 500000.
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(500000);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cur_bcd = '0;
        cur_ovf = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_bcd", 32'(bus.bcd_out), 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rsthold_done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_done", 32'(bus.done), 32'd0);
        convert(314159, 1'b0);
        idle_cycle();

        for (int n = 0; n < 24; n++) begin
            int unsigned v;
            if (n % 4 == 0) v = $urandom_range(1000000, (1 << BIN_W) - 1);
            else            v = $urandom_range(0, (1 << BIN_W) - 1);
            convert(v, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential shift-and-add-3 ("double dabble") converter from unsigned binary to 6-digit packed BCD. It sits directly upstream of the 6-digit seven-segment display driver and feeds its 24-bit val input. Each nibble of bcd_out is one decimal digit, and bits [3:0] are the least significant digit. bcd_out is a held register, so the display never shows intermediate conversion values.

Parameters:
BIN_W, 20, width of the binary input; legal range 1..20; one iteration per input bit.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
bin_in  in  BIN_W  unsigned binary value; sampled only on an accepted start
start  in  1  conversion request; accepted only in IDLE
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when bcd_out has just been updated
bcd_out  out  24  packed BCD result; holds its value between conversions
ovf  out  1  overflow flag for the last completed conversion (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, bcd_out=24'h000000, ovf=0. Internal scratch registers and the iteration counter are cleared.
- States:
  - IDLE: waiting for start.
  - SHIFT: performing iterations.
  - There is no separate DONE state.
- IDLE -> SHIFT: on the edge where start=1.
  - Capture bin_in into the shift register.
  - Clear the 24-bit BCD scratch register.
  - Set cnt=BIN_W.
  - Set busy=1.
- One iteration per clock edge in SHIFT:
  - For each of the 6 scratch nibbles, add 3 to the nibble if it is >=5.
  - Then shift {scratch, shreg} left by 1; the MSB of shreg enters scratch bit 0.
  - Decrement cnt.
  - Any carry out of scratch bit 23 is discarded.
- On the edge performing the final iteration (cnt==1):
  - Load bcd_out with the post-shift scratch value.
  - Set done=1 for exactly one cycle.
  - Set busy=0 and return to IDLE.
- Latency: start sampled at edge E0; done=1 and the new bcd_out are visible after edge E0+BIN_W. With the default BIN_W this gives 20 busy cycles.
- done is cleared on every edge that does not complete a conversion.
- start while busy=1 is ignored; it is not queued and has no effect on the result.
- start=1 in the done cycle: the state is already IDLE, so the start is accepted. This gives back-to-back conversions with no gap cycle.
- bcd_out and ovf keep their previous values for the whole conversion and change only on the completing edge.
- rst mid-conversion: immediate return to reset values; the partial result is discarded and done does not pulse.
- bin_in changing during a conversion has no effect.

Optional Feature:
Macro BIN_TO_BCD_OVF_EN.
- Defined:
  - At capture, compare bin_in > 999999 and store the result as an internal flag.
  - On completion, a flagged conversion drives bcd_out=24'hFFFFFF ("FFFFFF" on the display) and ovf=1.
  - A non-flagged conversion drives ovf=0.
  - ovf updates only on the completing edge.
  - When BIN_W<20 the comparison is constant-false and synthesises away.
- Not defined:
  - ovf is tied to 0 and no compare logic is built.
  - Inputs above 999999 produce bcd_out equal to (bin_in mod 1000000) in BCD, because the top digit is dropped.

Test Plan:
- Reset, then start with bin_in=0 -> busy=1 for 20 cycles; done pulses once; bcd_out=24'h000000; ovf=0.
- bin_in=123456 -> bcd_out=24'h123456 exactly 20 edges after the start edge. bcd_out must hold its old value throughout busy.
- bin_in=999999, then start in the done cycle with bin_in=65535 -> 24'h999999, then 24'h065535 with no idle cycle between conversions.
- bin_in=1048575 (20'hFFFFF):
  - With BIN_TO_BCD_OVF_EN -> bcd_out=24'hFFFFFF, ovf=1.
  - Without it -> bcd_out=24'h048575, ovf=0.
- Start with bin_in=42, then start pulses with bin_in=777 on cycles 3 and 10 of busy -> exactly one done; bcd_out=24'h000042.
- Assert rst at cycle 10 of a conversion of 500000 -> busy=0, done never pulses, bcd_out=0. A fresh start after reset converts correctly.
